// File: rtl/cache_pkg.sv
// cache_pkg: shared FSM state type and default geometry for cache_assoc.
package cache_pkg;
   localparam int ADDR_WIDTH_D = 32;
   localparam int DATA_WIDTH_D = 32;
   localparam int SETS_D       = 8;
   localparam int WAYS_D       = 2;

   typedef enum logic [1:0] {IDLE, COMPARE, FILL, WRITE} state_t;
endpackage

// File: rtl/cache_tag_array.sv
// cache_tag_array: one way's valid/tag/data storage, combinational read,
// synchronous write and clear-all of the valid bits.
module cache_tag_array #(
   parameter int SETS   = 8,
   parameter int IDX_W  = 3,
   parameter int TAG_W  = 27,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              we,
   input  logic [IDX_W-1:0]  idx,
   input  logic [TAG_W-1:0]  new_tag,
   input  logic [DATA_W-1:0] new_data,
   output logic              valid,
   output logic [TAG_W-1:0]  tag,
   output logic [DATA_W-1:0] data
);
   logic [SETS-1:0]   valid_bits;
   logic [TAG_W-1:0]  tag_mem [SETS];
   logic [DATA_W-1:0] data_mem [SETS];

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) valid_bits <= '0;
      else if (clear) valid_bits <= '0;
      else if (we) valid_bits[idx] <= 1'b1;

   always_ff @(posedge clk)
      if (we) begin
         tag_mem[idx]  <= new_tag;
         data_mem[idx] <= new_data;
      end

   assign valid = valid_bits[idx];
   assign tag   = tag_mem[idx];
   assign data  = data_mem[idx];
endmodule

// File: rtl/cache_assoc.sv
// cache_assoc: set-associative write-through, no-write-allocate cache.
// Define CACHE_ASSOC_STATS_EN to enable the saturating hit/miss counters.
module cache_assoc
   import cache_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_D,
   parameter int DATA_WIDTH = DATA_WIDTH_D,
   parameter int SETS       = SETS_D,
   parameter int WAYS       = WAYS_D
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_ready,
   input  logic                  cache_flush,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ack,
   output logic [31:0]           hit_count,
   output logic [31:0]           miss_count
);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = ADDR_WIDTH - 2 - IDX_W;
   localparam int WAY_W = WAYS > 1 ? $clog2(WAYS) : 1;

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  we;
   logic [DATA_WIDTH-1:0] wdata;
   logic [IDX_W-1:0]      idx;
   logic [TAG_W-1:0]      tag;
   logic [WAYS-1:0]       vld, match, wr_en;
   logic [TAG_W-1:0]      tags [WAYS];
   logic [DATA_WIDTH-1:0] datas [WAYS];
   logic [WAY_W-1:0]      rr [SETS];
   logic [WAY_W-1:0]      victim;
   logic [DATA_WIDTH-1:0] hit_data;
   logic                  hit, flush_all, fill_done, write_done;

   assign idx        = addr[2 +: IDX_W];
   assign tag        = addr[ADDR_WIDTH-1 -: TAG_W];
   assign hit        = |match;
   assign flush_all  = state == IDLE && cache_flush;
   assign fill_done  = state == FILL && mem_ack;
   assign write_done = state == WRITE && mem_ack;

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      cache_tag_array #(.SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W), .DATA_W(DATA_WIDTH)) u_way (
         .clk(clk), .rst_n(rst_n), .clear(flush_all), .we(wr_en[w]), .idx(idx),
         .new_tag(tag), .new_data(fill_done ? mem_rdata : wdata),
         .valid(vld[w]), .tag(tags[w]), .data(datas[w])
      );
      assign match[w] = vld[w] && tags[w] == tag;
   end

   // Descending scan so the lowest-numbered invalid way wins over the pointer
   always_comb begin
      victim   = rr[idx];
      hit_data = '0;
      wr_en    = '0;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (!vld[i]) victim = WAY_W'(i);
         if (match[i]) hit_data = datas[i];
      end
      for (int i = 0; i < WAYS; i++)
         wr_en[i] = (fill_done && victim == WAY_W'(i)) || (write_done && match[i]);
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         addr  <= '0;
         we    <= 1'b0;
         wdata <= '0;
         for (int s = 0; s < SETS; s++) rr[s] <= '0;
      end else begin
         case (state)
            IDLE:
               if (!cache_flush && cpu_req) begin
                  addr  <= cpu_addr;
                  we    <= cpu_we;
                  wdata <= cpu_wdata;
                  state <= COMPARE;
               end
            COMPARE: state <= we ? WRITE : hit ? IDLE : FILL;
            FILL:
               if (mem_ack) begin
                  state <= IDLE;
                  if (&vld) rr[idx] <= rr[idx] == WAY_W'(WAYS - 1) ? '0 : rr[idx] + 1'b1;
               end
            WRITE: if (mem_ack) state <= IDLE;
            default: state <= IDLE;
         endcase
      end

   assign cpu_ready = (state == COMPARE && !we && hit) || fill_done || write_done;
   assign cpu_rdata = state == FILL ? mem_rdata : hit_data;
   assign mem_req   = state == FILL || state == WRITE;
   assign mem_we    = state == WRITE;
   assign mem_addr  = addr;
   assign mem_wdata = wdata;

`ifdef CACHE_ASSOC_STATS_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (state == COMPARE) begin
         if (hit && !(&hit_count)) hit_count <= hit_count + 1'b1;
         if (!hit && !(&miss_count)) miss_count <= miss_count + 1'b1;
      end
`else
   assign hit_count  = '0;
   assign miss_count = '0;
`endif
endmodule

// File: tb/tb_cache_assoc.sv
// tb_cache_assoc: directed + random checks of cache_assoc (8 sets, 2 ways)
// against a set/way reference model and a 3-cycle-latency memory responder.
module tb_cache_assoc;
   localparam int S = 8;
   localparam int W = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_req = 1'b0, cpu_we = 1'b0, cache_flush = 1'b0;
   logic [31:0] cpu_addr = '0, cpu_wdata = '0;
   logic [31:0] cpu_rdata, mem_addr, mem_wdata, hit_count, miss_count;
   logic        cpu_ready, mem_req, mem_we;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   cache_assoc dut (
      .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
      .cache_flush(cache_flush), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   int tests = 0, fails = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] init_val(input logic [31:0] k);
      return k == 32'h40 ? 32'hDEADBEEF : (k * 32'h9E3779B1) ^ 32'hA5A50000;
   endfunction

   // Backing memory as seen by the DUT, plus what the responder last served
   logic [31:0] dut_mem [logic [31:0]];
   logic [31:0] last_addr, last_wdata;
   logic        last_we;
   bit          hold_ack = 0;
   int          dly = 0;

   initial begin
      mem_ack = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         if (!rst_n || hold_ack) begin
            mem_ack = 1'b0;
            dly = 0;
         end else if (mem_ack) begin
            mem_ack = 1'b0;
            dly = 0;
         end else if (mem_req) begin
            dly++;
            if (dly == 3) begin
               last_addr = mem_addr;
               last_we = mem_we;
               last_wdata = mem_wdata;
               if (mem_we) dut_mem[mem_addr & ~32'h3] = mem_wdata;
               else mem_rdata = dut_mem.exists(mem_addr & ~32'h3) ? dut_mem[mem_addr & ~32'h3]
                                                                 : init_val(mem_addr & ~32'h3);
               mem_ack = 1'b1;
            end
         end else dly = 0;
      end
   end

   // Reference model: per-set ways with valid/tag/data and a replacement pointer
   bit          mv [S][W];
   logic [26:0] mt [S][W];
   logic [31:0] md [S][W];
   int          mrr [S];
   logic [31:0] ref_mem [logic [31:0]];
   int          m_hits = 0, m_misses = 0;

   task automatic model_reset();
      for (int s = 0; s < S; s++) begin
         mrr[s] = 0;
         for (int i = 0; i < W; i++) mv[s][i] = 0;
      end
      m_hits = 0;
      m_misses = 0;
   endtask

   task automatic model_flush();
      for (int s = 0; s < S; s++)
         for (int i = 0; i < W; i++) mv[s][i] = 0;
   endtask

   task automatic model(input bit w, input logic [31:0] a, input logic [31:0] d,
                        output bit hit, output logic [31:0] rdata);
      int s, hw, vic;
      logic [31:0] k;
      s = int'(a[4:2]);
      k = a & ~32'h3;
      hw = -1;
      vic = -1;
      for (int i = 0; i < W; i++) if (mv[s][i] && mt[s][i] == a[31:5]) hw = i;
      hit = hw >= 0;
      rdata = '0;
      if (hit) m_hits++; else m_misses++;
      if (w) begin
         ref_mem[k] = d;
         if (hit) md[s][hw] = d;
      end else if (hit) rdata = md[s][hw];
      else begin
         for (int i = W - 1; i >= 0; i--) if (!mv[s][i]) vic = i;
         if (vic < 0) begin
            vic = mrr[s];
            mrr[s] = (mrr[s] + 1) % W;
         end
         rdata = ref_mem.exists(k) ? ref_mem[k] : init_val(k);
         mv[s][vic] = 1;
         mt[s][vic] = a[31:5];
         md[s][vic] = rdata;
      end
   endtask

   // want: 0 = expect miss, 1 = expect hit, 2 = take the model's verdict
   task automatic step(input bit w, input logic [31:0] a, input logic [31:0] d, input int want);
      bit m_hit, used_mem, done, exp_hit;
      logic [31:0] m_rd, rd;
      int lat;
      model(w, a, d, m_hit, m_rd);
      exp_hit = want == 2 ? m_hit : want == 1;
      @(negedge clk);
      cpu_req = 1'b1;
      cpu_we = w;
      cpu_addr = a;
      cpu_wdata = d;
      @(posedge clk);
      #1 cpu_req = 1'b0;
      lat = 0;
      used_mem = 0;
      done = 0;
      rd = '0;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         lat++;
         if (mem_req) used_mem = 1;
         if (cpu_ready) begin
            rd = cpu_rdata;
            done = 1;
         end
      end
      chk($sformatf("ready_seen %h", a), 32'(done), 32'd1);
      if (w) begin
         chk($sformatf("wr_mem_we %h", a), 32'(last_we), 32'd1);
         chk($sformatf("wr_mem_addr %h", a), last_addr, a);
         chk($sformatf("wr_mem_data %h", a), last_wdata, d);
      end else begin
         chk($sformatf("rd_hit %h", a), 32'(lat == 1 && !used_mem), 32'(exp_hit));
         if (!exp_hit) chk($sformatf("fill_addr %h", a), last_addr, a);
         chk($sformatf("rd_data %h", a), rd, m_rd);
      end
   endtask

   task automatic flush(input bit with_req);
      bit activity;
      model_flush();
      @(negedge clk);
      cache_flush = 1'b1;
      cpu_req = with_req;
      cpu_we = 1'b0;
      cpu_addr = 32'h40;
      @(posedge clk);
      #1 cache_flush = 1'b0;
      cpu_req = 1'b0;
      activity = 0;
      repeat (4) begin
         @(negedge clk);
         if (cpu_ready || mem_req) activity = 1;
      end
      chk("flush_blocks_req", 32'(activity), 32'd0);
   endtask

   task automatic chk_stats(input string tag);
`ifdef CACHE_ASSOC_STATS_EN
      chk({tag, "_hits"}, hit_count, 32'(m_hits));
      chk({tag, "_misses"}, miss_count, 32'(m_misses));
`else
      chk({tag, "_hits"}, hit_count, 32'd0);
      chk({tag, "_misses"}, miss_count, 32'd0);
`endif
   endtask

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(cpu_ready), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_hits", hit_count, 32'd0);
      chk("rst_misses", miss_count, 32'd0);
      rst_n = 1'b1;

      step(0, 32'h40, 0, 0);
      step(0, 32'h40, 0, 1);
      step(0, 32'h60, 0, 0);
      step(0, 32'h80, 0, 0);
      step(0, 32'h60, 0, 1);
      step(0, 32'h40, 0, 0);
      step(0, 32'h60, 0, 0);
      step(1, 32'h60, 32'h12345678, 2);
      step(0, 32'h60, 0, 1);
      step(1, 32'hA0, 32'hCAFEF00D, 2);
      step(0, 32'hA0, 0, 0);
      chk_stats("directed");

      flush(1'b1);
      step(0, 32'h40, 0, 0);
      step(0, 32'h60, 0, 0);
      step(0, 32'hA0, 0, 0);
      flush(1'b0);
      step(0, 32'h60, 0, 0);
      chk_stats("flush");

      for (int n = 0; n < 250; n++) begin
         logic [31:0] a;
         a = (32'($urandom_range(0, 3)) << 5) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 24) == 0) flush(1'b0);
         else step(1'($urandom_range(0, 3) == 0), a, $urandom, 2);
      end
      chk_stats("random");

      // Reset in the second FILL cycle abandons the transaction
      hold_ack = 1;
      @(negedge clk);
      cpu_req = 1'b1;
      cpu_we = 1'b0;
      cpu_addr = 32'h100;
      @(posedge clk);
      #1 cpu_req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("fill_req_up", 32'(mem_req), 32'd1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_drops_req", 32'(mem_req), 32'd0);
      chk("rst_no_ready", 32'(cpu_ready), 32'd0);
      model_reset();
      chk_stats("midreset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      hold_ack = 0;
      step(0, 32'h100, 0, 0);
      step(0, 32'h100, 0, 1);
      step(0, 32'h40, 0, 0);
      chk_stats("final");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/cache_assoc.md
CACHE_ASSOC -- requirements
Module: cache_assoc

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, word width (one word per line).
REQ-003 The block SHALL have parameter SETS, default 8, number of sets (power of two, >=2).
REQ-004 The block SHALL have parameter WAYS, default 2, associativity (power of two, >=1).
REQ-005 Ports SHALL be: clk  in  1  single clock, rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-006 Ports SHALL be: cpu_req  in  1  request strobe; cpu_we  in  1  1=write, 0=read; cpu_addr  in  ADDR_WIDTH  byte address; cpu_wdata  in  DATA_WIDTH  write data.
REQ-007 Ports SHALL be: cpu_rdata  out  DATA_WIDTH  read data; cpu_ready  out  1  one-cycle completion pulse; cache_flush  in  1  invalidate all lines.
REQ-008 Ports SHALL be: mem_req  out  1; mem_we  out  1; mem_addr  out  ADDR_WIDTH; mem_wdata  out  DATA_WIDTH; mem_rdata  in  DATA_WIDTH; mem_ack  in  1  backing-memory handshake.
REQ-009 Ports SHALL be: hit_count  out  32; miss_count  out  32  statistics (see Configuration).

Function
REQ-010 Address split SHALL be: offset = addr[1:0] (ignored), index = addr[2 +: log2(SETS)], tag = remaining upper bits; each way entry = {valid, tag, data}.
REQ-011 FSM states SHALL be IDLE, COMPARE, FILL, WRITE.
REQ-012 In IDLE, a request SHALL be accepted at a rising edge with cpu_req=1, latching addr/we/wdata; next state COMPARE; cpu_req outside IDLE SHALL be ignored.
REQ-013 In IDLE, cache_flush=1 SHALL clear every valid bit at that edge and take priority over cpu_req (request not accepted that cycle); flush outside IDLE SHALL be ignored.
REQ-014 In COMPARE, read hit (any valid way with matching tag) SHALL assert cpu_ready with the hit way's data on cpu_rdata for exactly that cycle, then return to IDLE; latency = 1 cycle after acceptance, no memory access.
REQ-015 In COMPARE, read miss SHALL go to FILL; FILL SHALL hold mem_req=1, mem_we=0, mem_addr=latched address until mem_ack=1.
REQ-016 On mem_ack in FILL, the victim way SHALL be written {1, tag, mem_rdata}, cpu_ready SHALL pulse with cpu_rdata=mem_rdata that cycle, next state IDLE.
REQ-017 Victim selection SHALL be the lowest-numbered invalid way; if none, the set's round-robin pointer, which SHALL increment (mod WAYS) only on replacement of a valid line.
REQ-018 Write (hit or miss) SHALL go to WRITE: mem_req=1, mem_we=1, mem_addr/mem_wdata = latched values until mem_ack (write-through).
REQ-019 On mem_ack in WRITE, a hitting way SHALL have its data updated; a miss SHALL NOT allocate (no-write-allocate); cpu_ready SHALL pulse; next state IDLE.
REQ-020 mem_req SHALL be deasserted in IDLE and COMPARE; mem_ack outside FILL/WRITE SHALL be ignored.
REQ-021 cpu_rdata SHALL be don't-care when cpu_ready=0; multiple matching ways SHALL not occur by construction.

Reset
REQ-022 rst_n low SHALL asynchronously force: state IDLE, all valid bits 0, round-robin pointers 0, cpu_ready 0, mem_req 0, mem_we 0, counters 0; data/tag arrays need not reset.
REQ-023 Reset during FILL/WRITE SHALL drop mem_req immediately and abandon the transaction without completing cpu_ready.

Configuration
REQ-024 Macro CACHE_ASSOC_STATS_EN defined: hit_count/miss_count SHALL increment (saturating at 2^32-1) once per COMPARE that resolves hit/miss respectively, reads and writes both counted.
REQ-025 Macro undefined: hit_count and miss_count SHALL be constant 0 and no counter registers synthesised; ports remain.

Structure
REQ-026 Package cache_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-027 Sub-module cache_tag_array SHALL hold one way's valid/tag/data storage with combinational read and synchronous write/clear-all; cache_assoc SHALL instantiate WAYS of them.

Verification (SETS=8, WAYS=2, memory ack delay 3 cycles)
REQ-028 After reset, read 0x40 -> mem_req, mem_addr=0x40; memory returns 0xDEADBEEF -> cpu_ready with 0xDEADBEEF; re-read 0x40 -> cpu_ready 1 cycle after acceptance, no mem_req.
REQ-029 Reads 0x40, 0x60, 0x80 (all index 0) -> third evicts way 0 (0x40); re-read 0x60 hits, re-read 0x40 misses.
REQ-030 Write 0x60=0x12345678 on resident line -> memory write seen, then read 0x60 hits returning 0x12345678; write 0xA0 (absent) -> memory write, following read 0xA0 misses.
REQ-031 cache_flush in IDLE after fills -> every subsequent read misses; hit_count/miss_count match expected totals with CACHE_ASSOC_STATS_EN, read 0 without.
REQ-032 rst_n asserted in the second FILL cycle -> mem_req 0 immediately, no cpu_ready, next read of same address misses.
